// File: rtl/score_ssd_driver.sv
// score_ssd_driver
//   Converts the 16-bit binary game score to four BCD digits with a
//   sequential double-dabble converter. It then scans those digits across
//   four active-low anodes of a 7-segment display.
//
//   Ports:
//     Clk     in   system clock
//     Reset   in   synchronous, active-high reset
//     Score   in   [15:0] unsigned score; values above 9999 display as 9999
//     ssdOut  out  [6:0] segments {Ca..Cg}, active low, registered
//     anode   out  [3:0] {An3..An0}, active low, one-hot-low, registered
//     Busy    out  high while a conversion is in progress
//
//   Converter: IDLE -> LOAD -> SHIFT x16 -> COMMIT -> IDLE.
//   The displayed digits only change in COMMIT, so a partial result never
//   reaches the display.
module score_ssd_driver #(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Score,
  output logic [6:0]  ssdOut,
  output logic [3:0]  anode,
  output logic        Busy
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [15:0]   last_q, last_d;   // raw Score of the most recent conversion
  logic [15:0]   bin_q, bin_d;     // binary half of the double-dabble register
  logic [15:0]   bcd_q, bcd_d;     // BCD accumulator
  logic [4:0]    cnt_q, cnt_d;
  logic [15:0]   dig_q, dig_d;     // committed digits {D3,D2,D1,D0}
  logic          busy_q, busy_d;
  logic [15:0]   adj;

  logic [CW-1:0] ref_q, ref_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    cur_dig;
  logic [15:0]   upper;
  logic          blank;

  // Converter next-state logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    busy_d  = busy_q;
    adj     = bcd_q;
    case (state_q)
      IDLE: begin
        if (Score != last_q) state_d = LOAD;
      end
      LOAD: begin
        bin_d   = (Score > 16'd9999) ? 16'd9999 : Score;
        last_d  = Score;
        bcd_d   = 16'd0;
        cnt_d   = 5'd0;
        busy_d  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        for (int i = 0; i < 4; i++) begin
          if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) state_d = COMMIT;
      end
      COMMIT: begin
        dig_d   = bcd_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scanner next-state and segment decode
  always_comb begin
    ref_d = ref_q + CW'(1);
    sel_d = sel_q;
    if (ref_q == REF_LAST) begin
      ref_d = '0;
      sel_d = sel_q + 2'd1;
    end
    anode_d = ~(4'b0001 << sel_q);
    cur_dig = dig_q[{sel_q, 2'b00} +: 4];
    // A slot is blank when it and every more significant digit are zero.
    upper   = dig_q >> {sel_q, 2'b00};
    blank   = BLANK_LEADING && (sel_q != 2'd0) && (upper == 16'd0);
    case (cur_dig)
      4'd0:    seg_d = 7'b0000001;
      4'd1:    seg_d = 7'b1001111;
      4'd2:    seg_d = 7'b0010010;
      4'd3:    seg_d = 7'b0000110;
      4'd4:    seg_d = 7'b1001100;
      4'd5:    seg_d = 7'b0100100;
      4'd6:    seg_d = 7'b0100000;
      4'd7:    seg_d = 7'b0001111;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0000100;
      default: seg_d = 7'b1111111;
    endcase
    if (blank) seg_d = 7'b1111111;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      last_q  <= 16'd0;
      bin_q   <= 16'd0;
      bcd_q   <= 16'd0;
      cnt_q   <= 5'd0;
      dig_q   <= 16'd0;
      busy_q  <= 1'b0;
      ref_q   <= '0;
      sel_q   <= 2'd0;
      anode_q <= 4'b1110;
      seg_q   <= 7'b0000001;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      busy_q  <= busy_d;
      ref_q   <= ref_d;
      sel_q   <= sel_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  assign ssdOut = seg_q;
  assign anode  = anode_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_score_ssd_driver.sv
// Directed testbench for score_ssd_driver. Two instances share clock,
// reset and score: u_dut blanks leading zeros, u_dut_nb shows all digits.
// Both use REFRESH_DIV=4 so a full scan frame is 16 cycles.
module tb_score_ssd_driver;

  // Segment patterns {Ca..Cg}, active low
  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                         S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                         S7 = 7'b0001111, S9 = 7'b0000100, SB = 7'b1111111;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] Score;
  logic [6:0]  ssdOut, ssdOut_nb;
  logic [3:0]  anode, anode_nb;
  logic        Busy, Busy_nb;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  score_ssd_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u_dut (
    .Clk(Clk), .Reset(Reset), .Score(Score),
    .ssdOut(ssdOut), .anode(anode), .Busy(Busy)
  );

  score_ssd_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u_dut_nb (
    .Clk(Clk), .Reset(Reset), .Score(Score),
    .ssdOut(ssdOut_nb), .anode(anode_nb), .Busy(Busy_nb)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one conversion after Score has been changed: counts the negedges
  // until Busy has risen and fallen again, and how many of those had Busy high.
  task automatic run_conv(output int edges, output int hi);
    bit seen;
    edges = 0;
    hi    = 0;
    seen  = 1'b0;
    while (edges < 60) begin
      @(negedge Clk);
      edges++;
      if (Busy) begin
        seen = 1'b1;
        hi++;
      end else if (seen) begin
        break;
      end
    end
    chk("conv_done", {30'd0, seen, Busy}, {30'd0, 1'b1, 1'b0});
  endtask

  // Aligns to the first cycle of the An0 slot, then checks one full
  // 16-cycle frame: each slot held exactly 4 cycles with its segments.
  task automatic check_frame(input string tag, input bit nb,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] exp_s [4];
    logic [3:0] exp_a;
    int n;
    exp_s = '{s0, s1, s2, s3};
    n = 0;
    while (((nb ? anode_nb : anode) == 4'b1110) && n < 40) begin @(negedge Clk); n++; end
    while (((nb ? anode_nb : anode) != 4'b1110) && n < 40) begin @(negedge Clk); n++; end
    chk({tag, "_align"}, (n < 40) ? 32'd1 : 32'd0, 32'd1);
    for (int k = 0; k < 16; k++) begin
      exp_a = ~(4'b0001 << (k / 4));
      chk({tag, "_anode"}, {28'd0, nb ? anode_nb : anode}, {28'd0, exp_a});
      chk({tag, "_seg"}, {25'd0, nb ? ssdOut_nb : ssdOut}, {25'd0, exp_s[k / 4]});
      @(negedge Clk);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int edges, hi, total_edges;
    logic [6:0] exp_seg;

    // Reset held 2 cycles with Score = 0
    Reset = 1'b1;
    Score = 16'd0;
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_anode", {28'd0, anode}, {28'd0, 4'b1110});
    chk("rst_seg", {25'd0, ssdOut}, {25'd0, S0});
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    Reset = 1'b0;

    // Score unchanged: Busy must never rise
    hi = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge Clk);
      if (Busy) hi++;
    end
    chk("idle_busy_cnt", hi, 0);
    check_frame("zero", 1'b0, S0, SB, SB, SB);

    // 0 -> 1234: Busy high 17 cycles, digits committed within 19 edges
    Score = 16'd1234;
    run_conv(edges, hi);
    chk("1234_busy_len", hi, 17);
    chk("1234_latency_ok", (edges <= 19) ? 32'd1 : 32'd0, 32'd1);
    check_frame("1234", 1'b0, S4, S3, S2, S1);

    // Saturation
    Score = 16'd12345;
    run_conv(edges, hi);
    check_frame("12345", 1'b0, S9, S9, S9, S9);
    Score = 16'd65535;
    run_conv(edges, hi);
    chk("65535_busy_len", hi, 17);
    check_frame("65535", 1'b0, S9, S9, S9, S9);

    // Leading-zero blanking, both instances
    Score = 16'd7;
    run_conv(edges, hi);
    check_frame("7_blank", 1'b0, S7, SB, SB, SB);
    check_frame("7_noblank", 1'b1, S7, S0, S0, S0);
    Score = 16'd1000;
    run_conv(edges, hi);
    check_frame("1000", 1'b0, S0, S0, S0, S1);

    // Score change on SHIFT cycle 5: 0055 commits first, then 9999
    Score = 16'd55;
    total_edges = 0;
    edges = 0;
    while (!Busy && edges < 10) begin @(negedge Clk); edges++; end
    chk("mid_busy_rise", {31'd0, Busy}, 32'd1);
    total_edges += edges;
    repeat (4) @(negedge Clk);
    total_edges += 4;
    Score = 16'd9999;
    edges = 0;
    while (Busy && edges < 30) begin @(negedge Clk); edges++; end
    chk("mid_first_commit", {31'd0, Busy}, 32'd0);
    total_edges += edges;
    // Segments lag the digits by one cycle; afterwards 0055 stays up for
    // the whole restarted conversion.
    @(negedge Clk);
    total_edges++;
    for (int k = 0; k < 16; k++) begin
      case (anode)
        4'b1110, 4'b1101: exp_seg = S5;
        default:          exp_seg = SB;
      endcase
      chk("mid_0055_seg", {25'd0, ssdOut}, {25'd0, exp_seg});
      @(negedge Clk);
      total_edges++;
    end
    chk("mid_restarted", {31'd0, Busy}, 32'd1);
    edges = 0;
    while (Busy && edges < 30) begin @(negedge Clk); edges++; end
    total_edges += edges;
    chk("mid_second_commit", {31'd0, Busy}, 32'd0);
    // Two back-to-back conversions, each committing 19 edges after its IDLE cycle
    chk("mid_latency_ok", (total_edges <= 38) ? 32'd1 : 32'd0, 32'd1);
    check_frame("9999", 1'b0, S9, S9, S9, S9);

    // Reset on SHIFT cycle 8 of a 4321 conversion
    Score = 16'd4321;
    edges = 0;
    while (!Busy && edges < 10) begin @(negedge Clk); edges++; end
    chk("rstmid_busy_rise", {31'd0, Busy}, 32'd1);
    repeat (7) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rstmid_anode", {28'd0, anode}, {28'd0, 4'b1110});
    chk("rstmid_seg", {25'd0, ssdOut}, {25'd0, S0});
    chk("rstmid_busy", {31'd0, Busy}, 32'd0);
    Reset = 1'b0;
    run_conv(edges, hi);
    chk("rstmid_busy_len", hi, 17);
    chk("rstmid_latency_ok", (edges <= 19) ? 32'd1 : 32'd0, 32'd1);
    check_frame("4321", 1'b0, S1, S2, S3, S4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
